// File: rtl/fb_pixel_writer_if.sv
// Renderer-to-framebuffer pixel stream: one pixel (x, y, colour index) per valid/ready transfer.
interface fb_pixel_writer_if;
  logic       px_valid;
  logic       px_ready;
  logic [9:0] px_x;
  logic [9:0] px_y;
  logic [3:0] px_color;

  modport master (
    output px_valid,
    output px_x,
    output px_y,
    output px_color,
    input  px_ready
  );

  modport slave (
    input  px_valid,
    input  px_x,
    input  px_y,
    input  px_color,
    output px_ready
  );
endinterface

// File: rtl/fb_pixel_writer.sv
// Framebuffer write front end: buffers renderer pixels, drops transparent/off-screen ones,
// drives the linear-address write port, and performs full-frame clears.
module fb_pixel_writer #(
  parameter int unsigned WIDTH      = 800,
  parameter int unsigned HEIGHT     = 480,
  parameter int unsigned ADDR_W     = 19,
  parameter int unsigned FIFO_DEPTH = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  fb_pixel_writer_if.slave  px,
  input  logic              clear_req,
  input  logic [3:0]        clear_color,
  output logic              busy,
  output logic              fb_we,
  output logic [ADDR_W-1:0] fb_addr,
  output logic [3:0]        fb_wdata
);

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned NPIX  = WIDTH * HEIGHT;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NPIX - 1);

  typedef enum logic {
    ST_IDLE,
    ST_CLEAR
  } state_e;

  typedef struct packed {
    logic [9:0] x;
    logic [9:0] y;
    logic [3:0] c;
  } pix_t;

  state_e            state_q;
  logic              run_q;
  logic [PTR_W:0]    wr_q;
  logic [PTR_W:0]    rd_q;
  pix_t              mem_q [FIFO_DEPTH];
  logic [ADDR_W-1:0] cnt_q;
  logic [3:0]        clr_color_q;
  logic              fb_we_q;
  logic [ADDR_W-1:0] fb_addr_q;
  logic [3:0]        fb_wdata_q;

  logic              fifo_empty;
  logic              fifo_full;
  logic              ready;
  logic              keep;
  logic              clear_go;
  logic              push;
  logic              pop;
  pix_t              head;
  logic [ADDR_W-1:0] head_addr;

  always_comb begin
    fifo_empty = (wr_q == rd_q);
    fifo_full  = (wr_q[PTR_W] != rd_q[PTR_W]) &&
                 (wr_q[PTR_W-1:0] == rd_q[PTR_W-1:0]);
    ready      = run_q && (state_q == ST_IDLE) && !fifo_full;
    keep       = (px.px_color != 4'hF) && (32'(px.px_x) < WIDTH) && (32'(px.px_y) < HEIGHT);
    clear_go   = (state_q == ST_IDLE) && clear_req;
    // A clear request wins over both the incoming pixel and the FIFO head that cycle.
    push       = px.px_valid && ready && keep && !clear_go;
    pop        = (state_q == ST_IDLE) && !fifo_empty && !clear_go;
    head       = mem_q[rd_q[PTR_W-1:0]];
    head_addr  = ADDR_W'(head.y) * ADDR_W'(WIDTH) + ADDR_W'(head.x);
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_q[PTR_W-1:0]] <= '{x: px.px_x, y: px.px_y, c: px.px_color};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      run_q       <= 1'b0;
      wr_q        <= '0;
      rd_q        <= '0;
      cnt_q       <= '0;
      clr_color_q <= '0;
      fb_we_q     <= 1'b0;
      fb_addr_q   <= '0;
      fb_wdata_q  <= '0;
    end else begin
      run_q   <= 1'b1;
      fb_we_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (clear_go) begin
            state_q     <= ST_CLEAR;
            cnt_q       <= '0;
            clr_color_q <= clear_color;
            wr_q        <= '0;
            rd_q        <= '0;
          end else begin
            if (push) begin
              wr_q <= wr_q + 1'b1;
            end
            if (pop) begin
              rd_q       <= rd_q + 1'b1;
              fb_we_q    <= 1'b1;
              fb_addr_q  <= head_addr;
              fb_wdata_q <= head.c;
            end
          end
        end
        ST_CLEAR: begin
          fb_we_q    <= 1'b1;
          fb_addr_q  <= cnt_q;
          fb_wdata_q <= clr_color_q;
          cnt_q      <= cnt_q + 1'b1;
          if (cnt_q == LAST_ADDR) begin
            state_q <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign px.px_ready = ready;
  assign busy        = (state_q == ST_CLEAR) || !fifo_empty || fb_we_q;
  assign fb_we       = fb_we_q;
  assign fb_addr     = fb_addr_q;
  assign fb_wdata    = fb_wdata_q;

endmodule

// File: tb/tb_fb_pixel_writer.sv
// Scoreboard bench for fb_pixel_writer on a reduced 40x30 frame so full clears stay short.
module tb_fb_pixel_writer;

  localparam int unsigned W    = 40;
  localparam int unsigned H    = 30;
  localparam int unsigned AW   = 19;
  localparam int          NPIX = W * H;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          clear_req;
  logic [3:0]    clear_color;
  logic          busy;
  logic          fb_we;
  logic [AW-1:0] fb_addr;
  logic [3:0]    fb_wdata;

  always #5 clk = ~clk;

  fb_pixel_writer_if px ();

  fb_pixel_writer #(
    .WIDTH      (W),
    .HEIGHT     (H),
    .ADDR_W     (AW),
    .FIFO_DEPTH (16)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .px          (px),
    .clear_req   (clear_req),
    .clear_color (clear_color),
    .busy        (busy),
    .fb_we       (fb_we),
    .fb_addr     (fb_addr),
    .fb_wdata    (fb_wdata)
  );

  typedef struct {
    int addr;
    int data;
  } wr_t;

  wr_t sb[$];
  wr_t mon_e;
  int  checks = 0;
  int  errors = 0;
  int  ncyc = 0;
  int  last_we_cyc = -1;
  int  run = 0;
  int  last_run = 0;

  always @(posedge clk) ncyc <= ncyc + 1;

  task automatic check(input string nm, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Monitor: every presented write must match the head of the scoreboard.
  always @(negedge clk) begin
    if (rst_n && fb_we) begin
      last_we_cyc = ncyc;
      run++;
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write: addr=%0d data=%0d, none expected", fb_addr, fb_wdata);
      end else begin
        mon_e = sb.pop_front();
        check("write_addr", int'(fb_addr), mon_e.addr);
        check("write_data", int'(fb_wdata), mon_e.data);
      end
    end else begin
      if (run > 0) last_run = run;
      run = 0;
    end
  end

  task automatic sync();
    @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input int a, input int d);
    wr_t t;
    t.addr = a;
    t.data = d;
    sb.push_back(t);
  endtask

  task automatic idle();
    px.px_valid = 1'b0;
    clear_req   = 1'b0;
  endtask

  // Presents one pixel (valid left high for back-to-back use); returns the handshake cycle.
  task automatic send_px(input int x, input int y, input int c, input bit exp_wr,
                         input bit with_clear, output int hs);
    px.px_valid = 1'b1;
    px.px_x     = 10'(x);
    px.px_y     = 10'(y);
    px.px_color = 4'(c);
    clear_req   = with_clear;
    hs = -1;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (px.px_ready) begin
        hs = ncyc;
        break;
      end
    end
    if (hs < 0) begin
      checks++;
      errors++;
      $display("FAIL handshake_timeout: pixel (%0d,%0d) never accepted", x, y);
    end else if (exp_wr) begin
      push_exp(y * W + x, c);
    end
    @(posedge clk);
    #1;
    clear_req = 1'b0;
  endtask

  task automatic issue_clear(input int c, input bit exp);
    clear_req   = 1'b1;
    clear_color = 4'(c);
    sync();
    clear_req = 1'b0;
    if (exp) for (int i = 0; i < NPIX; i++) push_exp(i, c);
  endtask

  task automatic wait_empty(input int maxc, input string nm);
    int i;
    i = 0;
    while (sb.size() != 0 && i < maxc) begin
      @(negedge clk);
      #1;
      i++;
    end
    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL %s: %0d writes outstanding after %0d cycles, expected 0", nm, sb.size(), maxc);
      sb.delete();
    end
  endtask

  initial begin
    #600000;
    $display("FAIL watchdog: simulation did not complete in time");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
    $fatal(1);
  end

  initial begin
    int hs;
    int hs0;

    // Reset with a transparent pixel already offered.
    clear_req   = 1'b0;
    clear_color = '0;
    px.px_valid = 1'b1;
    px.px_x     = '0;
    px.px_y     = '0;
    px.px_color = 4'hF;
    #23;
    check("rst_px_ready", int'(px.px_ready), 0);
    check("rst_fb_we", int'(fb_we), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_fb_addr", int'(fb_addr), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    #1;
    check("release_px_ready", int'(px.px_ready), 1);
    sync();
    idle();

    // Single pixel: (5,2) -> 2*40+5 = 85.
    sync();
    send_px(5, 2, 7, 1'b1, 1'b0, hs);
    idle();
    wait_empty(20, "single_drain");
    check("single_latency", last_we_cyc, hs + 2);
    repeat (3) @(negedge clk);
    check("single_busy_after", int'(busy), 0);

    // Filters: all accepted back-to-back, only the (39,29) corner is written (addr 1199).
    sync();
    send_px(0, 0, 15, 1'b0, 1'b0, hs0);
    send_px(800, 0, 1, 1'b0, 1'b0, hs);
    check("filter_ready_1", hs, hs0 + 1);
    send_px(W, 0, 2, 1'b0, 1'b0, hs);
    check("filter_ready_2", hs, hs0 + 2);
    send_px(0, H, 3, 1'b0, 1'b0, hs);
    check("filter_ready_3", hs, hs0 + 3);
    send_px(W - 1, H - 1, 4, 1'b1, 1'b0, hs);
    idle();
    wait_empty(20, "filter_drain");
    repeat (3) @(negedge clk);
    check("filter_busy_after", int'(busy), 0);

    // Full clear to colour 3.
    sync();
    issue_clear(3, 1'b1);
    repeat (500) @(negedge clk);
    check("clear_px_ready", int'(px.px_ready), 0);
    check("clear_busy", int'(busy), 1);
    wait_empty(NPIX + 20, "clear_drain");
    check("clear_busy_last_write", int'(busy), 1);
    @(negedge clk);
    #1;
    check("clear_busy_fall", int'(busy), 0);
    check("clear_consecutive", last_run, NPIX);

    // Backpressure: 20 pixels offered while a clear holds px_ready low.
    sync();
    issue_clear(5, 1'b1);
    @(negedge clk);
    #1;
    check("bp_px_ready_low", int'(px.px_ready), 0);
    sync();
    for (int i = 0; i < 20; i++) send_px(2 * i + 1, i, i % 15, 1'b1, 1'b0, hs);
    idle();
    wait_empty(NPIX + 200, "bp_drain");
    @(negedge clk);
    sync();
    for (int i = 0; i < 16; i++) send_px(i + 10, 20, i % 15, 1'b1, 1'b0, hs);
    idle();
    wait_empty(60, "burst_drain");
    @(negedge clk);
    #1;
    check("burst_consecutive", last_run, 16);

    // Clear racing pixels: P1,P2 already popped get written, P3 (queued) and P4 (same cycle) do not.
    sync();
    send_px(3, 3, 1, 1'b1, 1'b0, hs0);
    send_px(4, 3, 2, 1'b1, 1'b0, hs);
    send_px(5, 3, 6, 1'b0, 1'b0, hs);
    clear_color = 4'd8;
    send_px(6, 3, 9, 1'b0, 1'b1, hs);
    check("race_clear_ready", hs, hs0 + 3);
    idle();
    for (int i = 0; i < NPIX; i++) push_exp(i, 8);
    repeat (100) @(negedge clk);
    sync();
    issue_clear(12, 1'b0);
    wait_empty(NPIX + 50, "race_drain");
    @(negedge clk);
    #1;
    check("race_clear_consecutive", last_run, NPIX);
    check("race_busy_after", int'(busy), 0);

    // Reset lands as clear write 1000 is presented.
    sync();
    issue_clear(9, 1'b0);
    for (int i = 0; i < 1000; i++) push_exp(i, 9);
    wait_empty(1100, "reset_clear_drain");
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("midclear_rst_fb_we", int'(fb_we), 0);
    check("midclear_rst_busy", int'(busy), 0);
    check("midclear_rst_ready", int'(px.px_ready), 0);
    idle();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    #1;
    check("post_rst_ready", int'(px.px_ready), 1);
    check("post_rst_busy", int'(busy), 0);
    sync();
    send_px(7, 1, 11, 1'b1, 1'b0, hs);
    idle();
    wait_empty(20, "post_rst_drain");
    check("post_rst_latency", last_we_cyc, hs + 2);

    repeat (20) @(negedge clk);
    check("sb_empty_at_end", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
